// File: rtl/seq_arith_pkg.sv
// Shared encodings and helpers for the sequential (multi-cycle) arithmetic blocks.
// Holds the multiplier encodings and the constant-time divider state map.
package seq_arith_pkg;

    // Multiplier control encodings
    typedef enum logic [1:0] {
        MUL_IDLE  = 2'd0,
        MUL_INIT  = 2'd1,
        MUL_ADD   = 2'd2,
        MUL_FINAL = 2'd3
    } mul_state_e;

    localparam int MUL_STATE_W = 2;

    // Divider state numbering: IDLE, INIT, then SHIFT_i/TEST_i pairs from
    // i = WIDTH-1 down to 0, then FINAL. SHIFT states are even, TEST states odd.
    localparam int DIV_ST_IDLE = 0;
    localparam int DIV_ST_INIT = 1;

    function automatic int div_state_width(input int width);
        return $clog2(2 * width + 3);
    endfunction

    function automatic int div_st_shift(input int width, input int i);
        return 2 + 2 * (width - 1 - i);
    endfunction

    function automatic int div_st_test(input int width, input int i);
        return 3 + 2 * (width - 1 - i);
    endfunction

    function automatic int div_st_final(input int width);
        return 2 * width + 2;
    endfunction

    // Decoded kind of a divider state, used by the control FSM
    typedef enum logic [2:0] {
        PH_IDLE  = 3'd0,
        PH_INIT  = 3'd1,
        PH_SHIFT = 3'd2,
        PH_TEST  = 3'd3,
        PH_FINAL = 3'd4
    } div_phase_e;

endpackage

// File: rtl/divider_control_constant_time.sv
// Control FSM of the constant-time restoring divider: walks a fixed
// INIT / SHIFT_i / TEST_i / FINAL sequence and issues datapath strobes.
module divider_control_constant_time
    import seq_arith_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic ge,
    output logic load,
    output logic clear,
    output logic shift,
    output logic subtract,
    output logic busy,
    output logic quotientDone
);

    localparam int SW = div_state_width(WIDTH);
    localparam logic [SW-1:0] ST_IDLE  = SW'(DIV_ST_IDLE);
    localparam logic [SW-1:0] ST_INIT  = SW'(DIV_ST_INIT);
    localparam logic [SW-1:0] ST_FINAL = SW'(div_st_final(WIDTH));

    logic [SW-1:0] state;
    logic [SW-1:0] state_next;
    div_phase_e    phase;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Unreachable encodings above FINAL decode as IDLE so the FSM self-recovers
    always_comb begin
        phase = PH_IDLE;
        if (state == ST_IDLE) begin
            phase = PH_IDLE;
        end else if (state == ST_INIT) begin
            phase = PH_INIT;
        end else if (state == ST_FINAL) begin
            phase = PH_FINAL;
        end else if (state > ST_FINAL) begin
            phase = PH_IDLE;
        end else if (state[0]) begin
            phase = PH_TEST;
        end else begin
            phase = PH_SHIFT;
        end
    end

    // INIT, SHIFT_i and TEST_i all advance to the next numbered state; TEST_0 + 1 is FINAL
    always_comb begin
        state_next   = state;
        load         = 1'b0;
        clear        = 1'b0;
        shift        = 1'b0;
        subtract     = 1'b0;
        quotientDone = 1'b0;
        busy         = (phase != PH_IDLE);
        unique case (phase)
            PH_IDLE: begin
                state_next = start ? ST_INIT : ST_IDLE;
            end
            PH_INIT: begin
                load       = 1'b1;
                clear      = 1'b1;
                state_next = state + SW'(1);
            end
            PH_SHIFT: begin
                shift      = 1'b1;
                state_next = state + SW'(1);
            end
            PH_TEST: begin
                subtract   = ge;
                state_next = state + SW'(1);
            end
            PH_FINAL: begin
                quotientDone = 1'b1;
                state_next   = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/divider_constant_time.sv
// Constant-time unsigned restoring divider: datapath registers, comparator and
// subtractor, sequenced by divider_control_constant_time.
module divider_constant_time
    import seq_arith_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             quotientDone,
    output logic             divByZero,
    output logic             busy
);

    logic [WIDTH-1:0] quo_reg;
    logic [WIDTH-1:0] dvs_reg;
    logic [WIDTH:0]   rem_reg;
    logic             dbz_reg;

    logic load;
    logic clear;
    logic shift;
    logic subtract;
    logic ge;

    // Compare at WIDTH+1 bits: the shifted partial remainder can reach 2*divisor-1
    assign ge = (rem_reg >= {1'b0, dvs_reg});

    divider_control_constant_time #(
        .WIDTH(WIDTH)
    ) u_control (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .ge          (ge),
        .load        (load),
        .clear       (clear),
        .shift       (shift),
        .subtract    (subtract),
        .busy        (busy),
        .quotientDone(quotientDone)
    );

    // A zero divisor always compares ge, so every quotient bit sets and the
    // remainder ends up equal to the dividend with no special-case path
    always_ff @(posedge clk) begin
        if (rst) begin
            quo_reg <= '0;
            dvs_reg <= '0;
            rem_reg <= '0;
            dbz_reg <= 1'b0;
        end else begin
            if (load) begin
                dvs_reg <= divisor;
                dbz_reg <= (divisor == '0);
            end

            if (load) begin
                quo_reg <= dividend;
            end else if (shift) begin
                quo_reg <= {quo_reg[WIDTH-2:0], 1'b0};
            end else if (subtract) begin
                quo_reg[0] <= 1'b1;
            end

            if (clear) begin
                rem_reg <= '0;
            end else if (shift) begin
                rem_reg <= {rem_reg[WIDTH-1:0], quo_reg[WIDTH-1]};
            end else if (subtract) begin
                rem_reg <= rem_reg - {1'b0, dvs_reg};
            end
        end
    end

    assign quotient  = quo_reg;
    assign remainder = rem_reg[WIDTH-1:0];
    assign divByZero = dbz_reg;

endmodule

// File: tb/tb_divider_constant_time.sv
// Directed bench for divider_constant_time (WIDTH=4) with hand-computed results.
module tb_divider_constant_time;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         quotientDone;
    logic         divByZero;
    logic         busy;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    divider_constant_time #(
        .WIDTH(W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .quotientDone(quotientDone),
        .divByZero   (divByZero),
        .busy        (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $display("FAIL %s: observed %0d expected %0d", tag, observed, expected);
            $error("miscompare on %s", tag);
        end
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_quotient"},  32'(quotient),     32'd0);
        check({tag, "_remainder"}, 32'(remainder),    32'd0);
        check({tag, "_dbz"},       32'(divByZero),    32'd0);
        check({tag, "_done"},      32'(quotientDone), 32'd0);
        check({tag, "_busy"},      32'(busy),         32'd0);
    endtask

    // Start pulse in cycle 0; operands scrambled and stray start pulses
    // applied while busy; results expected in cycle 10 and held in cycle 11.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input int exp_q, input int exp_r, input int exp_dbz,
                          input string tag);
        int early_done;
        int not_busy;
        early_done = 0;
        not_busy   = 0;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            if (quotientDone) early_done++;
            if (!busy) not_busy++;
            if (c == 2) begin
                dividend = ~a;
                divisor  = a ^ b ^ 4'd5;
            end
            start = (c >= 4 && c <= 6);
            tick();
        end
        check({tag, "_early_done"}, 32'(early_done), 32'd0);
        check({tag, "_busy_gap"},   32'(not_busy),   32'd0);
        check({tag, "_done_c10"},   32'(quotientDone), 32'd1);
        check({tag, "_q_c10"},      32'(quotient),   32'(exp_q));
        check({tag, "_r_c10"},      32'(remainder),  32'(exp_r));
        check({tag, "_dbz_c10"},    32'(divByZero),  32'(exp_dbz));
        tick();
        check({tag, "_done_c11"},   32'(quotientDone), 32'd0);
        check({tag, "_busy_c11"},   32'(busy),       32'd0);
        check({tag, "_q_hold"},     32'(quotient),   32'(exp_q));
        check({tag, "_r_hold"},     32'(remainder),  32'(exp_r));
        check({tag, "_dbz_hold"},   32'(divByZero),  32'(exp_dbz));
    endtask

    initial begin
        int bad_done;
        int idle_busy;

        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        tick();
        tick();
        check_cleared("reset");
        rst = 1'b0;
        tick();

        run_op(4'd13, 4'd3, 4, 1, 0, "d13_3");
        run_op(4'd15, 4'd1, 15, 0, 0, "d15_1");
        run_op(4'd5, 4'd9, 0, 5, 0, "d5_9");
        run_op(4'd7, 4'd0, 15, 7, 1, "d7_0");
        run_op(4'd15, 4'd15, 1, 0, 0, "d15_15");
        run_op(4'd0, 4'd5, 0, 0, 0, "d0_5");

        // Abort 12/5 with reset in cycle 5
        dividend = 4'd12;
        divisor  = 4'd5;
        start    = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 5; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_cleared("abort_c6");
        bad_done  = 0;
        idle_busy = 0;
        for (int c = 6; c <= 13; c++) begin
            if (quotientDone) bad_done++;
            if (busy) idle_busy++;
            tick();
        end
        check("abort_no_done", 32'(bad_done),  32'd0);
        check("abort_no_busy", 32'(idle_busy), 32'd0);
        run_op(4'd9, 4'd2, 4, 1, 0, "d9_2_after_abort");

        // Reset wins over start in the same cycle
        rst      = 1'b1;
        start    = 1'b1;
        dividend = 4'd15;
        divisor  = 4'd1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        check_cleared("rst_prio_c1");
        tick();
        check("rst_prio_busy_c2", 32'(busy), 32'd0);

        // start held high for cycles 0..24 with 9/4
        dividend = 4'd9;
        divisor  = 4'd4;
        start    = 1'b1;
        bad_done = 0;
        for (int c = 1; c <= 33; c++) begin
            tick();
            if (c == 25) start = 1'b0;
            if (quotientDone !== (c == 10 || c == 21 || c == 32)) bad_done++;
            if (c == 10 || c == 21) begin
                check($sformatf("b2b_q_c%0d", c), 32'(quotient),  32'd2);
                check($sformatf("b2b_r_c%0d", c), 32'(remainder), 32'd1);
            end
            if (c == 11 || c == 22) begin
                check($sformatf("b2b_busy_c%0d", c), 32'(busy), 32'd0);
            end
        end
        check("b2b_done_pattern", 32'(bad_done), 32'd0);
        check("b2b_idle_busy",    32'(busy),      32'd0);
        check("b2b_final_q",      32'(quotient),  32'd2);
        check("b2b_final_r",      32'(remainder), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
